// File: rtl/vbuf_chain_arb.sv
// vbuf_chain_arb: two-requester round-robin arbiter feeding a fixed-latency
// chain of DEPTH registered buffer stages. The whole chain advances together
// whenever the last stage is empty or being drained; empty slots travel as
// bubbles, so an accepted beat reaches the output after DEPTH clock edges
// in the absence of stalls.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req0_valid/data/ready       requester 0 handshake (ready is combinational)
//   req1_valid/data/ready       requester 1 handshake (ready is combinational)
//   out_valid/data/src          last stage contents
//   out_ready                   downstream accept
//   occupancy                   count of valid beats held in the chain
module vbuf_chain_arb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [3:0]       occupancy
);

    localparam int unsigned OCC_W = 4;

    typedef struct packed {
        logic             valid;
        logic             src;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t             stage_q [DEPTH];
    stage_t             stage_d [DEPTH];
    logic               ptr_q;
    logic               ptr_d;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               advance;
    logic               gnt0;
    logic               gnt1;
    logic               drain;

    // Arbitration: grants are gated by rst so readies stay low during reset.
    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        advance = !stage_q[DEPTH-1].valid || out_ready;
        if (!rst && advance) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Chain shift, pointer and occupancy next-state.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i];
        end
        ptr_d = ptr_q;
        drain = stage_q[DEPTH-1].valid && out_ready;

        if (advance) begin
            // Bubbles carry zero payload so idle request data never leaks in.
            stage_d[0].valid = gnt0 || gnt1;
            stage_d[0].src   = gnt1;
            stage_d[0].data  = gnt1 ? req1_data : (gnt0 ? req0_data : '0);
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end

        occ_d = OCC_W'(occ_q + OCC_W'(gnt0 || gnt1) - OCC_W'(drain));
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
            ptr_q <= 1'b0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_d[i];
            end
            ptr_q <= ptr_d;
            occ_q <= occ_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign out_valid  = stage_q[DEPTH-1].valid;
    assign out_src    = stage_q[DEPTH-1].src;
    assign out_data   = stage_q[DEPTH-1].data;
    assign occupancy  = occ_q;

endmodule

// File: doc/vbuf_chain_arb.md
VBUF_CHAIN_ARB -- requirements
Module: vbuf_chain_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of registered buffer stages (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1 each  requester offers data.
REQ-006 SHALL have ports req0_data/req1_data  input  WIDTH each  requester payload.
REQ-007 SHALL have ports req0_ready/req1_ready  output  1 each  requester's beat accepted this cycle.
REQ-008 SHALL have port out_valid  output  1  last stage holds a beat.
REQ-009 SHALL have port out_data  output  WIDTH  payload of last stage.
REQ-010 SHALL have port out_src  output  1  requester index that produced out_data.
REQ-011 SHALL have port out_ready  input  1  downstream sink accepts.
REQ-012 SHALL have port occupancy  output  4  number of valid beats in the chain.

Function
REQ-013 SHALL implement DEPTH stages, each holding {valid, src, data}; stage 0 loads from the arbiter, stage DEPTH-1 drives out_*.
REQ-014 SHALL define advance = !out_valid | out_ready; when advance=1 every stage shifts one position in the same cycle, otherwise all stages hold.
REQ-015 SHALL, when advance=1 and no requester is granted, load stage 0 with valid=0 (bubble).
REQ-016 SHALL grant at most one requester per cycle, only when advance=1; reqN_ready = grant to N (combinational from reqN_valid, pointer, out_valid, out_ready).
REQ-017 SHALL arbitrate round-robin: pointer ptr names the preferred requester; if both valid, grant ptr; if one valid, grant it.
REQ-018 SHALL set ptr to the non-granted index after every grant; ptr holds when nothing is granted.
REQ-019 SHALL give latency exactly DEPTH cycles from acceptance edge to out_valid=1 when no stall occurs.
REQ-020 SHALL preserve beat order; a beat SHALL not be duplicated or dropped under any out_ready pattern.
REQ-021 SHALL update occupancy each cycle: +1 on accept, -1 on out_valid&out_ready, unchanged when both or neither; it never exceeds DEPTH.
REQ-022 SHALL allow simultaneous accept and drain at full occupancy (throughput 1 beat/cycle when out_ready=1).
REQ-023 SHALL keep out_data/out_src stable while out_valid=1 and out_ready=0.
REQ-024 SHALL not depend on reqN_data when reqN_valid=0.

Reset
REQ-025 SHALL, on rst=1, clear all stage valids, ptr=0, occupancy=0, regardless of clk.
REQ-026 SHALL drive out_valid=0, out_src=0, out_data=0, req0_ready=req1_ready=0 while rst=1.
REQ-027 SHALL discard all in-flight beats when rst asserts mid-operation; none reappear after release.
REQ-028 SHALL accept a beat on the first rising edge after rst deasserts.

Verification
REQ-029 Single beat: DEPTH=4, req0_valid=1 data=0xA5 one cycle, out_ready=1 -> out_valid=1, out_data=0xA5, out_src=0 exactly 4 cycles later, occupancy 1 then 0.
REQ-030 Contention: both requesters valid continuously, data0=0x10+n, data1=0x20+n -> grants alternate 0,1,0,1; out_src alternates from first output; 1 beat/cycle.
REQ-031 Backpressure: fill chain, out_ready=0 for 6 cycles -> occupancy=4, reqN_ready=0, out_data stable; release -> 4 beats in order, no loss.
REQ-032 Full-throughput: occupancy=4, out_ready=1, req1_valid=1 -> accept and drain same cycle, occupancy stays 4.
REQ-033 Reset mid-stream: 3 beats in flight, pulse rst asynchronously between edges -> outputs 0 immediately, occupancy 0, no stale beat emerges after release.
REQ-034 Pointer hold: only req1 valid for 3 beats then both valid -> first contended grant goes to req0.
